// File: rtl/move_cmd_buffer_pkg.sv
// move_cmd_buffer_pkg: shared rapcore command definitions (command codes, API
// version, status word layout, word width) and the move parser state type.
package move_cmd_buffer_pkg;
  localparam int WORD_W = 64;
  localparam logic [7:0] CMD_COORDINATED_STEP = 8'h01;
  localparam logic [7:0] CMD_MOTOR_ENABLE = 8'h0A;
  localparam logic [7:0] CMD_CLK_DIVISOR = 8'h0B;
  localparam logic [7:0] CMD_STATUS = 8'h0C;
  localparam logic [7:0] CMD_MOVE_FLUSH = 8'h0D;
  localparam logic [7:0] CMD_API_VERSION = 8'hFE;
  localparam logic [7:0] VERSION_MAJOR = 8'd1;
  localparam logic [7:0] VERSION_MINOR = 8'd2;
  localparam logic [7:0] VERSION_PATCH = 8'd3;
  localparam int STATUS_OVERFLOW_BIT = 63;
  localparam int STATUS_COUNT_W = 16;
  typedef enum logic [1:0] {IDLE, DURATION, INC, INCINC} parse_state_t;
  function automatic logic [WORD_W-1:0] status_word(input logic ovf, input logic [STATUS_COUNT_W-1:0] cnt);
    status_word = '0;
    status_word[STATUS_OVERFLOW_BIT] = ovf;
    status_word[STATUS_COUNT_W-1:0] = cnt;
  endfunction
endpackage

// File: rtl/move_cmd_buffer_fifo.sv
// move_cmd_buffer_fifo: move FIFO with wrapping pointers and combinational head.
// Ports: CLK, resetn (sync, active-low); push/din enqueue, pop dequeues the head,
// flush empties (rd_ptr <= wr_ptr) and overrides push/pop; dout is the head
// entry, count the occupancy, dropped flags a push refused because full.
module move_cmd_buffer_fifo #(
  parameter int W = 8,
  parameter int DB = 2
) (
  input  logic          CLK,
  input  logic          resetn,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [DB:0]   count,
  output logic          dropped
);
  localparam int DEPTH = 1 << DB;
  localparam logic [DB:0] FULL = DEPTH;
  logic [W-1:0] mem_q [DEPTH];
  logic [DB-1:0] wr_q, rd_q;
  logic [DB:0] cnt_q;
  logic do_push, do_pop;
  assign do_pop = pop && cnt_q != '0;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (cnt_q < FULL || do_pop);
  assign dropped = push && !do_push;
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else if (flush) begin
      rd_q <= wr_q;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + 1'b1;
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{DB{1'b0}}, do_push} - {{DB{1'b0}}, do_pop};
    end
  end
  always_ff @(posedge CLK) if (do_push && !flush) mem_q[wr_q] <= din;
endmodule

// File: rtl/move_cmd_buffer.sv
// move_cmd_buffer: decodes 64-bit SPI command words for NUM_AXES coordinated
// axes, holds enable/clock_divisor, stages multi-word moves and commits them
// atomically into a 2**DEPTH_BITS move FIFO served by a valid/ack handshake.
// Ports: CLK, resetn (sync, active-low); word_valid/word_data/word_abort from
// SPI, word_send_data reply; encoder_count snapshot source; enable,
// clock_divisor globals; move_* head of FIFO with move_ack pop; buffer_count,
// buffer_dtr, sticky overflow.
// Optional macro MOVE_FLUSH_EN: adds input halt and command 0x0D MOVE_FLUSH.
module move_cmd_buffer
  import move_cmd_buffer_pkg::*;
#(
  parameter int NUM_AXES = 1,
  parameter int DEPTH_BITS = 2,
  parameter int DEFAULT_CLK_DIV = 40
) (
  input  logic                     CLK,
  input  logic                     resetn,
  input  logic                     word_valid,
  input  logic [WORD_W-1:0]        word_data,
  input  logic                     word_abort,
  output logic [WORD_W-1:0]        word_send_data,
  input  logic [64*NUM_AXES-1:0]   encoder_count,
`ifdef MOVE_FLUSH_EN
  input  logic                     halt,
`endif
  output logic                     enable,
  output logic [7:0]               clock_divisor,
  output logic                     move_valid,
  input  logic                     move_ack,
  output logic [NUM_AXES-1:0]      move_dir,
  output logic [63:0]              move_duration,
  output logic [64*NUM_AXES-1:0]   move_increment,
  output logic [64*NUM_AXES-1:0]   move_incrementincrement,
  output logic [DEPTH_BITS:0]      buffer_count,
  output logic                     buffer_dtr,
  output logic                     overflow
);
  localparam int AXW = NUM_AXES > 1 ? $clog2(NUM_AXES) : 1;
  localparam int FW = NUM_AXES + 64 + 128 * NUM_AXES;
  localparam logic [AXW-1:0] LAST = AXW'(NUM_AXES - 1);
  localparam logic [DEPTH_BITS:0] DEPTH = 1 << DEPTH_BITS;
  parse_state_t state_q, state_d;
  logic [AXW-1:0] ax_q, ax_d, ax_nx;
  logic [NUM_AXES-1:0] dir_q, dir_d;
  logic [63:0] dur_q, dur_d;
  logic [NUM_AXES-1:0][63:0] inc_q, inc_d, incinc_q, incinc_d, snap_q, snap_d;
  logic [WORD_W-1:0] reply_q, reply_d, status;
  logic enable_q, enable_d, overflow_q, overflow_d;
  logic [7:0] clkdiv_q, clkdiv_d;
  logic commit, ovf_clr, push, flush, dropped;
  logic [DEPTH_BITS:0] count;
  logic [FW-1:0] head;
`ifdef MOVE_FLUSH_EN
  logic flush_cmd;
`endif
  assign ax_nx = ax_q + 1'b1;
  assign status = status_word(overflow_q, STATUS_COUNT_W'(count));
  always_comb begin
    state_d = state_q;
    ax_d = ax_q;
    dir_d = dir_q;
    dur_d = dur_q;
    inc_d = inc_q;
    incinc_d = incinc_q;
    snap_d = snap_q;
    reply_d = reply_q;
    enable_d = enable_q;
    clkdiv_d = clkdiv_q;
    commit = 1'b0;
    ovf_clr = 1'b0;
`ifdef MOVE_FLUSH_EN
    flush_cmd = 1'b0;
`endif
    if (word_abort) begin
      state_d = IDLE;
      ax_d = '0;
      dir_d = '0;
      dur_d = '0;
      inc_d = '0;
      incinc_d = '0;
      snap_d = '0;
    end else if (word_valid) begin
      reply_d = '0;
      case (state_q)
        IDLE:
          case (word_data[63:56])
            CMD_COORDINATED_STEP: begin
              dir_d = word_data[NUM_AXES-1:0];
              snap_d = encoder_count;
              reply_d = status;
              state_d = DURATION;
            end
            CMD_MOTOR_ENABLE: enable_d = word_data[0];
            CMD_CLK_DIVISOR: clkdiv_d = word_data[7:0] == 8'd0 ? 8'd1 : word_data[7:0];
            CMD_STATUS: begin
              reply_d = status;
              ovf_clr = word_data[0];
            end
            CMD_API_VERSION: reply_d = {40'd0, VERSION_MAJOR, VERSION_MINOR, VERSION_PATCH};
`ifdef MOVE_FLUSH_EN
            CMD_MOVE_FLUSH: flush_cmd = 1'b1;
`endif
            default: ;
          endcase
        DURATION: begin
          dur_d = word_data;
          reply_d = snap_q[0];
          ax_d = '0;
          state_d = INC;
        end
        INC: begin
          inc_d[ax_q] = word_data;
          state_d = INCINC;
        end
        INCINC: begin
          incinc_d[ax_q] = word_data;
          if (ax_q == LAST) begin
            commit = 1'b1;
            ax_d = '0;
            state_d = IDLE;
          end else begin
            reply_d = snap_q[ax_nx];
            ax_d = ax_nx;
            state_d = INC;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end
`ifdef MOVE_FLUSH_EN
  // Moves landing while halted vanish without counting as overflow.
  assign push = commit & ~halt;
  assign flush = halt | flush_cmd;
`else
  assign push = commit;
  assign flush = 1'b0;
`endif
  assign overflow_d = (overflow_q & ~ovf_clr) | dropped;
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state_q <= IDLE;
      ax_q <= '0;
      dir_q <= '0;
      dur_q <= '0;
      inc_q <= '0;
      incinc_q <= '0;
      snap_q <= '0;
      reply_q <= '0;
      enable_q <= 1'b0;
      clkdiv_q <= 8'(DEFAULT_CLK_DIV);
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ax_q <= ax_d;
      dir_q <= dir_d;
      dur_q <= dur_d;
      inc_q <= inc_d;
      incinc_q <= incinc_d;
      snap_q <= snap_d;
      reply_q <= reply_d;
      enable_q <= enable_d;
      clkdiv_q <= clkdiv_d;
      overflow_q <= overflow_d;
    end
  end
  // The last acceleration word is taken straight from incinc_d so the move
  // commits on the same edge that captures its final word.
  move_cmd_buffer_fifo #(.W(FW), .DB(DEPTH_BITS)) u_fifo (
    .CLK(CLK),
    .resetn(resetn),
    .push(push),
    .pop(move_ack),
    .flush(flush),
    .din({dir_q, dur_q, inc_q, incinc_d}),
    .dout(head),
    .count(count),
    .dropped(dropped)
  );
  assign {move_dir, move_duration, move_increment, move_incrementincrement} = head;
  assign word_send_data = reply_q;
  assign enable = enable_q;
  assign clock_divisor = clkdiv_q;
  assign overflow = overflow_q;
  assign buffer_count = count;
  assign move_valid = count != '0;
  assign buffer_dtr = count < DEPTH;
endmodule

// File: tb/tb_move_cmd_buffer.sv
// tb_move_cmd_buffer: scoreboard bench for move_cmd_buffer with NUM_AXES=2,
// DEPTH_BITS=2; expected replies and moves are queued at drive time.
module tb_move_cmd_buffer;
  logic CLK = 1'b0, resetn = 1'b0, word_valid = 1'b0, word_abort = 1'b0, move_ack = 1'b0, halt = 1'b0;
  logic [63:0] word_data = '0, word_send_data, move_duration;
  logic [127:0] encoder_count = '0, move_increment, move_incrementincrement;
  logic enable, move_valid, buffer_dtr, overflow;
  logic [7:0] clock_divisor;
  logic [1:0] move_dir;
  logic [2:0] buffer_count;
  int checks = 0, errors = 0;
  typedef struct packed {
    logic [1:0] dir;
    logic [63:0] dur;
    logic [1:0][63:0] inc;
    logic [1:0][63:0] incinc;
  } mv_t;
  mv_t exp_q[$];
  logic [63:0] rep_q[$];
  int m_count = 0;
  logic m_ovf = 1'b0;

  always #5 CLK = ~CLK;

  move_cmd_buffer #(.NUM_AXES(2), .DEPTH_BITS(2), .DEFAULT_CLK_DIV(40)) dut (
    .CLK(CLK), .resetn(resetn), .word_valid(word_valid), .word_data(word_data),
    .word_abort(word_abort), .word_send_data(word_send_data), .encoder_count(encoder_count),
`ifdef MOVE_FLUSH_EN
    .halt(halt),
`endif
    .enable(enable), .clock_divisor(clock_divisor), .move_valid(move_valid), .move_ack(move_ack),
    .move_dir(move_dir), .move_duration(move_duration), .move_increment(move_increment),
    .move_incrementincrement(move_incrementincrement), .buffer_count(buffer_count),
    .buffer_dtr(buffer_dtr), .overflow(overflow)
  );

  function automatic logic [63:0] status();
    return {m_ovf, 47'd0, 16'(m_count)};
  endfunction

  function automatic mv_t mk(input int i);
    mv_t m;
    m.dir = 2'(i);
    m.dur = 64'(100 + i);
    m.inc = {64'(i * 3), 64'(i * 2)};
    m.incinc = {-64'(i), 64'(i)};
    return m;
  endfunction

  task automatic send_word(input logic [63:0] d, input logic [63:0] exp, input logic ack);
    logic [63:0] e;
    @(negedge CLK);
    word_data = d;
    word_valid = 1'b1;
    move_ack = ack;
    rep_q.push_back(exp);
    @(negedge CLK);
    word_valid = 1'b0;
    move_ack = 1'b0;
    e = rep_q.pop_front();
    checks++;
    if (word_send_data !== e) begin
      errors++;
      $display("FAIL reply word=%h got %h exp %h", d, word_send_data, e);
    end
  endtask

  task automatic send_move(input mv_t m, input logic [63:0] ea, input logic [63:0] eb, input logic ack_last);
    encoder_count = {eb, ea};
    send_word({8'h01, 54'd0, m.dir}, status(), 1'b0);
    encoder_count = ~encoder_count;
    send_word(m.dur, ea, 1'b0);
    send_word(m.inc[0], 64'd0, 1'b0);
    send_word(m.incinc[0], eb, 1'b0);
    send_word(m.inc[1], 64'd0, 1'b0);
    if (ack_last && m_count != 0) begin
      void'(exp_q.pop_front());
      m_count--;
    end
    if (!halt) begin
      if (m_count < 4) begin
        exp_q.push_back(m);
        m_count++;
      end else m_ovf = 1'b1;
    end
    send_word(m.incinc[1], 64'd0, ack_last);
  endtask

  task automatic pop_and_compare(input string name);
    mv_t got;
    got = {move_dir, move_duration, move_increment, move_incrementincrement};
    checks++;
    if (!move_valid || exp_q.size() == 0 || got !== exp_q[0]) begin
      errors++;
      $display("FAIL %s head valid=%b got %h exp %h", name, move_valid, got, exp_q.size() ? exp_q[0] : mv_t'('x));
    end
    @(negedge CLK);
    move_ack = 1'b1;
    @(negedge CLK);
    move_ack = 1'b0;
    if (exp_q.size() != 0) begin
      void'(exp_q.pop_front());
      m_count--;
    end
    checks++;
    if (buffer_count !== 3'(m_count)) begin
      errors++;
      $display("FAIL %s count after pop got %0d exp %0d", name, buffer_count, m_count);
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (3) @(negedge CLK);
    resetn = 1'b1;
    @(negedge CLK);
    checks++;
    if ({enable, clock_divisor, move_valid, buffer_dtr, word_send_data, buffer_count, overflow} !==
        {1'b0, 8'd40, 1'b0, 1'b1, 64'd0, 3'd0, 1'b0}) begin
      errors++;
      $display("FAIL reset en=%b div=%0d mv=%b dtr=%b send=%h cnt=%0d ovf=%b exp 0 40 0 1 0 0 0",
               enable, clock_divisor, move_valid, buffer_dtr, word_send_data, buffer_count, overflow);
    end
  endtask

  task automatic test_move();
    mv_t m;
    m.dir = 2'b10;
    m.dur = 64'd1000;
    m.inc = {64'd7, 64'd5};
    m.incinc = {-64'sd1, 64'd0};
    send_move(m, 64'd11, 64'd22, 1'b0);
    checks++;
    if (move_valid !== 1'b1 || buffer_count !== 3'd1) begin
      errors++;
      $display("FAIL move_commit valid=%b cnt=%0d exp 1 1", move_valid, buffer_count);
    end
    pop_and_compare("move");
    checks++;
    if (move_valid !== 1'b0) begin
      errors++;
      $display("FAIL move_empty valid=%b exp 0", move_valid);
    end
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 5; i++) send_move(mk(i), 64'(10 * i), 64'(10 * i + 1), 1'b0);
    checks++;
    if ({overflow, buffer_count, buffer_dtr} !== {1'b1, 3'd4, 1'b0}) begin
      errors++;
      $display("FAIL overflow ovf=%b cnt=%0d dtr=%b exp 1 4 0", overflow, buffer_count, buffer_dtr);
    end
    send_word({8'h0C, 55'd0, 1'b1}, status(), 1'b0);
    m_ovf = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL status_clear ovf=%b exp 0", overflow);
    end
  endtask

  task automatic test_back_to_back();
    send_move(mk(6), 64'd60, 64'd61, 1'b1);
    checks++;
    if ({buffer_count, overflow} !== {3'd4, 1'b0}) begin
      errors++;
      $display("FAIL push_pop cnt=%0d ovf=%b exp 4 0", buffer_count, overflow);
    end
    for (int i = 0; i < 4; i++) pop_and_compare("drain");
  endtask

  task automatic test_abort();
    send_word({8'h0A, 55'd0, 1'b1}, 64'd0, 1'b0);
    encoder_count = {64'd5, 64'd4};
    send_word({8'h01, 54'd0, 2'b11}, status(), 1'b0);
    send_word(64'd9, 64'd4, 1'b0);
    send_word(64'd9, 64'd0, 1'b0);
    @(negedge CLK);
    word_abort = 1'b1;
    word_valid = 1'b1;
    word_data = {8'h0A, 56'd0};
    @(negedge CLK);
    word_abort = 1'b0;
    word_valid = 1'b0;
    checks++;
    if ({buffer_count, enable} !== {3'd0, 1'b1}) begin
      errors++;
      $display("FAIL abort cnt=%0d en=%b exp 0 1", buffer_count, enable);
    end
    send_move(mk(7), 64'd70, 64'd71, 1'b0);
    pop_and_compare("after_abort");
    send_word({8'h0B, 56'd0}, 64'd0, 1'b0);
    checks++;
    if (clock_divisor !== 8'd1) begin
      errors++;
      $display("FAIL clkdiv0 got %0d exp 1", clock_divisor);
    end
    send_word({8'h0B, 48'd0, 8'd37}, 64'd0, 1'b0);
    checks++;
    if (clock_divisor !== 8'd37) begin
      errors++;
      $display("FAIL clkdiv got %0d exp 37", clock_divisor);
    end
    send_word({8'hFE, 56'd0}, 64'h0000_0000_0001_0203, 1'b0);
    send_word({8'h55, 56'd0}, 64'd0, 1'b0);
  endtask

  task automatic test_reset_mid();
    send_move(mk(8), 64'd80, 64'd81, 1'b0);
    send_word({8'h01, 54'd0, 2'b01}, status(), 1'b0);
    send_word(64'd3, encoder_count[63:0], 1'b0);
    @(negedge CLK);
    resetn = 1'b0;
    @(negedge CLK);
    resetn = 1'b1;
    exp_q.delete();
    m_count = 0;
    m_ovf = 1'b0;
    @(negedge CLK);
    checks++;
    if ({buffer_count, move_valid, enable, clock_divisor} !== {3'd0, 1'b0, 1'b0, 8'd40}) begin
      errors++;
      $display("FAIL reset_mid cnt=%0d mv=%b en=%b div=%0d exp 0 0 0 40", buffer_count, move_valid, enable, clock_divisor);
    end
    send_move(mk(9), 64'd90, 64'd91, 1'b0);
`ifndef MOVE_FLUSH_EN
    send_word({8'h0D, 56'd0}, 64'd0, 1'b0);
`endif
    pop_and_compare("after_reset");
  endtask

`ifdef MOVE_FLUSH_EN
  task automatic test_flush();
    for (int i = 10; i < 13; i++) send_move(mk(i), 64'(i), 64'(i + 1), 1'b0);
    @(negedge CLK);
    halt = 1'b1;
    @(negedge CLK);
    exp_q.delete();
    m_count = 0;
    checks++;
    if ({buffer_count, move_valid} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL halt cnt=%0d mv=%b exp 0 0", buffer_count, move_valid);
    end
    send_move(mk(13), 64'd13, 64'd14, 1'b0);
    checks++;
    if ({buffer_count, overflow} !== {3'd0, 1'b0}) begin
      errors++;
      $display("FAIL halt_commit cnt=%0d ovf=%b exp 0 0", buffer_count, overflow);
    end
    halt = 1'b0;
    send_move(mk(14), 64'd1, 64'd2, 1'b0);
    send_word({8'h0D, 56'd0}, 64'd0, 1'b0);
    exp_q.delete();
    m_count = 0;
    checks++;
    if (buffer_count !== 3'd0) begin
      errors++;
      $display("FAIL flush_cmd cnt=%0d exp 0", buffer_count);
    end
    send_move(mk(15), 64'd3, 64'd4, 1'b0);
    pop_and_compare("after_flush");
  endtask
`endif

  initial begin
    test_reset();
    test_move();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_reset_mid();
`ifdef MOVE_FLUSH_EN
    test_flush();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
